// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC, F/D and D/E pipeline registers driven by the hazard unit.
// Next PC is resolved in D (one delay slot), so F/D never needs a flush.
// Also keeps saturating stall/bubble counters and a sticky handshake checker.
module pipe_front_regs #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic [31:0]      instr_f,
    input  logic [1:0]       npc_sel_d,
    input  logic             br_taken_d,
    input  logic [31:0]      jr_target_d,
    input  logic [31:0]      rd1_d,
    input  logic [31:0]      rd2_d,
    input  logic [31:0]      imm32_d,
    output logic [31:0]      pc_f,
    output logic [31:0]      ir_d,
    output logic [31:0]      pc4_d,
    output logic [31:0]      ir_e,
    output logic [31:0]      pc4_e,
    output logic [31:0]      rd1_e,
    output logic [31:0]      rd2_e,
    output logic [31:0]      imm32_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             proto_err
);

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BEQ = 2'b01;
    localparam logic [1:0] SEL_J   = 2'b10;
    localparam logic [1:0] SEL_JR  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] npc;
    logic        proto_bad;

    assign pc_plus4  = pc_f + 32'd4;
    assign br_offset = {{14{ir_d[15]}}, ir_d[15:0], 2'b00};

    // Handshake is consistent only when F and D agree and a bubble accompanies every stall.
    assign proto_bad = (StallF != StallD) || (FlushE == StallD);

    // Select the next fetch address from the D-stage control-flow decision.
    always_comb begin
        npc = pc_plus4;
        case (npc_sel_d)
            SEL_SEQ: npc = pc_plus4;
            SEL_BEQ: npc = br_taken_d ? (pc4_d + br_offset) : pc_plus4;
            SEL_J:   npc = {pc4_d[31:28], ir_d[25:0], 2'b00};
            SEL_JR:  npc = jr_target_d;
            default: npc = pc_plus4;
        endcase
    end

    // PC advances only when enabled; a held PC drops the D-stage redirect so it re-evaluates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f <= PC_RESET;
        end else if (StallF) begin
            pc_f <= npc;
        end
    end

    // F/D captures the fetched instruction and its return address when enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_d  <= '0;
            pc4_d <= '0;
        end else if (StallD) begin
            ir_d  <= instr_f;
            pc4_d <= pc_plus4;
        end
    end

    // D/E loads every cycle; a flush inserts an all-zero nop bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_e    <= '0;
            pc4_e   <= '0;
            rd1_e   <= '0;
            rd2_e   <= '0;
            imm32_e <= '0;
        end else if (FlushE) begin
            ir_e    <= '0;
            pc4_e   <= '0;
            rd1_e   <= '0;
            rd2_e   <= '0;
            imm32_e <= '0;
        end else begin
            ir_e    <= ir_d;
            pc4_e   <= pc4_d;
            rd1_e   <= rd1_d;
            rd2_e   <= rd2_d;
            imm32_e <= imm32_d;
        end
    end

    // Saturating counters of stalled-decode cycles and inserted bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (!StallD && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (FlushE && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    // Sticky flag: any inconsistent stall/flush combination latches until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proto_err <= 1'b0;
        end else if (proto_bad) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs: directed vector table, async-reset sequence, randomized run
// against a behavioural model, and counter saturation for pipe_front_regs.
module tb_pipe_front_regs;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushE;
    logic [31:0] instr_f;
    logic [1:0]  npc_sel_d;
    logic        br_taken_d;
    logic [31:0] jr_target_d, rd1_d, rd2_d, imm32_d;
    logic [31:0] pc_f, ir_d, pc4_d, ir_e, pc4_e, rd1_e, rd2_e, imm32_e;
    logic [15:0] stall_cnt, bubble_cnt;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] m_pc, m_ir_d, m_pc4_d, m_ir_e, m_pc4_e, m_rd1_e, m_rd2_e, m_imm_e;
    int          m_stall, m_bubble;
    logic        m_proto;

    typedef struct {
        logic        sf;
        logic        sd;
        logic        fe;
        logic [31:0] instr;
        logic [1:0]  sel;
        logic        taken;
        logic [31:0] jr;
        logic [31:0] rd1;
        logic [31:0] e_pc;
        logic [31:0] e_ir_d;
        logic [31:0] e_ir_e;
        logic [31:0] e_rd1_e;
        logic [15:0] e_stall;
        logic [15:0] e_bubble;
        logic        e_proto;
    } vec_t;

    vec_t tbl [13];

    pipe_front_regs #(.PC_RESET(PC_RESET), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .instr_f(instr_f), .npc_sel_d(npc_sel_d), .br_taken_d(br_taken_d),
        .jr_target_d(jr_target_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm32_d(imm32_d),
        .pc_f(pc_f), .ir_d(ir_d), .pc4_d(pc4_d), .ir_e(ir_e), .pc4_e(pc4_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm32_e(imm32_e),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_pc = PC_RESET;
        m_ir_d = 0; m_pc4_d = 0;
        m_ir_e = 0; m_pc4_e = 0; m_rd1_e = 0; m_rd2_e = 0; m_imm_e = 0;
        m_stall = 0; m_bubble = 0; m_proto = 1'b0;
    endtask

    // One clock edge of the architectural rules, using the values before the edge.
    task automatic modelStep();
        logic [31:0] target;
        int          off;
        target = m_pc + 32'd4;
        case (npc_sel_d)
            2'd1: if (br_taken_d) begin
                      off = int'($signed(m_ir_d[15:0]));
                      target = m_pc4_d + 32'(off * 4);
                  end
            2'd2: target = (m_pc4_d & 32'hF000_0000) | ((m_ir_d & 32'h03FF_FFFF) << 2);
            2'd3: target = jr_target_d;
            default: ;
        endcase
        if ((StallF != StallD) || (FlushE == StallD)) m_proto = 1'b1;
        if (!StallD) m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
        if (FlushE)  m_bubble = (m_bubble + 1 > 65535) ? 65535 : m_bubble + 1;
        if (FlushE) begin
            m_ir_e = 0; m_pc4_e = 0; m_rd1_e = 0; m_rd2_e = 0; m_imm_e = 0;
        end else begin
            m_ir_e = m_ir_d; m_pc4_e = m_pc4_d; m_rd1_e = rd1_d; m_rd2_e = rd2_d; m_imm_e = imm32_d;
        end
        if (StallD) begin
            m_ir_d = instr_f;
            m_pc4_d = m_pc + 32'd4;
        end
        if (StallF) m_pc = target;
    endtask

    task automatic applyStimulus(input logic sf, input logic sd, input logic fe,
                                 input logic [31:0] instr, input logic [1:0] sel,
                                 input logic tk, input logic [31:0] jr,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] imm);
        StallF = sf; StallD = sd; FlushE = fe;
        instr_f = instr; npc_sel_d = sel; br_taken_d = tk;
        jr_target_d = jr; rd1_d = r1; rd2_d = r2; imm32_d = imm;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " pc_f"},       pc_f,       m_pc);
        checkOutput({tag, " ir_d"},       ir_d,       m_ir_d);
        checkOutput({tag, " pc4_d"},      pc4_d,      m_pc4_d);
        checkOutput({tag, " ir_e"},       ir_e,       m_ir_e);
        checkOutput({tag, " pc4_e"},      pc4_e,      m_pc4_e);
        checkOutput({tag, " rd1_e"},      rd1_e,      m_rd1_e);
        checkOutput({tag, " rd2_e"},      rd2_e,      m_rd2_e);
        checkOutput({tag, " imm32_e"},    imm32_e,    m_imm_e);
        checkOutput({tag, " stall_cnt"},  {16'h0, stall_cnt},  32'(m_stall));
        checkOutput({tag, " bubble_cnt"}, {16'h0, bubble_cnt}, 32'(m_bubble));
        checkOutput({tag, " proto_err"},  {31'h0, proto_err},  {31'h0, m_proto});
    endtask

    initial begin
        // sf sd fe instr sel tk jr rd1 | pc ir_d ir_e rd1_e stall bubble proto
        tbl[0]  = '{1'b1,1'b1,1'b0,32'hA000_0000,2'd0,1'b0,32'h0,32'h11, 32'h3004,32'hA000_0000,32'h0,32'h11,16'd0,16'd0,1'b0};
        tbl[1]  = '{1'b1,1'b1,1'b0,32'hA100_0000,2'd0,1'b0,32'h0,32'h12, 32'h3008,32'hA100_0000,32'hA000_0000,32'h12,16'd0,16'd0,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b0,32'hA200_0000,2'd0,1'b0,32'h0,32'h13, 32'h300C,32'hA200_0000,32'hA100_0000,32'h13,16'd0,16'd0,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b1,32'hA300_0000,2'd0,1'b0,32'h0,32'h14, 32'h300C,32'hA200_0000,32'h0,32'h0,16'd1,16'd1,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b0,32'hA300_0000,2'd3,1'b0,32'h3004,32'h15, 32'h3004,32'hA300_0000,32'hA200_0000,32'h15,16'd1,16'd1,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b0,32'h1000_FFFF,2'd0,1'b0,32'h0,32'h16, 32'h3008,32'h1000_FFFF,32'hA300_0000,32'h16,16'd1,16'd1,1'b0};
        tbl[6]  = '{1'b1,1'b1,1'b0,32'hB000_0000,2'd1,1'b1,32'h0,32'h17, 32'h3004,32'hB000_0000,32'h1000_FFFF,32'h17,16'd1,16'd1,1'b0};
        tbl[7]  = '{1'b1,1'b1,1'b0,32'h0800_0C00,2'd0,1'b0,32'h0,32'h18, 32'h3008,32'h0800_0C00,32'hB000_0000,32'h18,16'd1,16'd1,1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b0,32'hB100_0000,2'd2,1'b0,32'h0,32'h19, 32'h3000,32'hB100_0000,32'h0800_0C00,32'h19,16'd1,16'd1,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b1,32'hB200_0000,2'd3,1'b0,32'h4000,32'h1A, 32'h3000,32'hB100_0000,32'h0,32'h0,16'd2,16'd2,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b0,32'hB200_0000,2'd3,1'b0,32'h4000,32'h1B, 32'h4000,32'hB200_0000,32'hB100_0000,32'h1B,16'd2,16'd2,1'b0};
        tbl[11] = '{1'b1,1'b0,1'b0,32'hB300_0000,2'd0,1'b0,32'h0,32'h1C, 32'h4004,32'hB200_0000,32'hB200_0000,32'h1C,16'd3,16'd2,1'b1};
        tbl[12] = '{1'b1,1'b1,1'b0,32'hB400_0000,2'd0,1'b0,32'h0,32'h1D, 32'h4008,32'hB400_0000,32'hB200_0000,32'h1D,16'd3,16'd2,1'b1};

        StallF = 1'b1; StallD = 1'b1; FlushE = 1'b0;
        instr_f = 0; npc_sel_d = 0; br_taken_d = 0;
        jr_target_d = 0; rd1_d = 0; rd2_d = 0; imm32_d = 0;

        // reset held for two cycles, released away from the edge
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("reset pc_f",       pc_f,                 PC_RESET);
        checkOutput("reset ir_d",       ir_d,                 32'h0);
        checkOutput("reset ir_e",       ir_e,                 32'h0);
        checkOutput("reset stall_cnt",  {16'h0, stall_cnt},   32'h0);
        checkOutput("reset bubble_cnt", {16'h0, bubble_cnt},  32'h0);
        checkOutput("reset proto_err",  {31'h0, proto_err},   32'h0);

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].sf, tbl[i].sd, tbl[i].fe, tbl[i].instr, tbl[i].sel,
                          tbl[i].taken, tbl[i].jr, tbl[i].rd1, ~tbl[i].rd1, 32'hC000 + 32'(i));
            checkOutput($sformatf("vec%0d pc_f", i),       pc_f,                tbl[i].e_pc);
            checkOutput($sformatf("vec%0d ir_d", i),       ir_d,                tbl[i].e_ir_d);
            checkOutput($sformatf("vec%0d ir_e", i),       ir_e,                tbl[i].e_ir_e);
            checkOutput($sformatf("vec%0d rd1_e", i),      rd1_e,               tbl[i].e_rd1_e);
            checkOutput($sformatf("vec%0d stall_cnt", i),  {16'h0, stall_cnt},  {16'h0, tbl[i].e_stall});
            checkOutput($sformatf("vec%0d bubble_cnt", i), {16'h0, bubble_cnt}, {16'h0, tbl[i].e_bubble});
            checkOutput($sformatf("vec%0d proto_err", i),  {31'h0, proto_err},  {31'h0, tbl[i].e_proto});
        end

        // reset asserted in the middle of a stall acts immediately
        StallF = 1'b0; StallD = 1'b0; FlushE = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("midreset pc_f",      pc_f,               PC_RESET);
        checkOutput("midreset ir_d",      ir_d,               32'h0);
        checkOutput("midreset ir_e",      ir_e,               32'h0);
        checkOutput("midreset stall_cnt", {16'h0, stall_cnt}, 32'h0);
        checkOutput("midreset proto_err", {31'h0, proto_err}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hD000_0001, 2'd0, 1'b0, 32'h0, 32'h1, 32'h2, 32'h3);
        checkModel("restart");
        checkOutput("restart pc_f", pc_f, 32'h3004);

        // randomized run against the model
        for (int n = 0; n < 1500; n++) begin
            int mode;
            logic sf, sd, fe;
            mode = $urandom_range(0, 9);
            if (mode <= 6) begin
                sf = 1'b1; sd = 1'b1; fe = 1'b0;
            end else if (mode <= 8) begin
                sf = 1'b0; sd = 1'b0; fe = 1'b1;
            end else begin
                sf = 1'($urandom); sd = 1'($urandom); fe = 1'($urandom);
            end
            applyStimulus(sf, sd, fe, $urandom, 2'($urandom), 1'($urandom),
                          $urandom, $urandom, $urandom, $urandom);
            checkModel($sformatf("rand%0d", n));
        end

        // counter saturation from a clean reset with a long load-use stall
        reset = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
        StallF = 1'b0; StallD = 1'b0; FlushE = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        checkOutput("sat stall_cnt at 65535",  {16'h0, stall_cnt},  32'h0000_FFFF);
        checkOutput("sat bubble_cnt at 65535", {16'h0, bubble_cnt}, 32'h0000_FFFF);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sat stall_cnt hold",  {16'h0, stall_cnt},  32'h0000_FFFF);
        checkOutput("sat bubble_cnt hold", {16'h0, bubble_cnt}, 32'h0000_FFFF);
        checkOutput("sat proto_err",       {31'h0, proto_err},  32'h0);
        checkOutput("sat pc_f held",       pc_f,                PC_RESET);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
